vending_change_dispenser: RTL and testbench
===========================================

# vending_change_dispenser

Drives the coin hopper that returns change after a vending transaction: takes a change amount in CNY and ejects 5, 2 and 1 CNY coins one at a time, using a greedy selection and a command/acknowledge handshake with the hopper. It sits downstream of the coin-accepting vending FSM, which computes the overpayment and hands it over on a valid/ready handshake. Empty denominations are skipped, and a missing hopper acknowledge is reported as a fault.

## Interface
- AMT_W, 4, width of change amount and remaining count (max 15 CNY)
- ACK_TIMEOUT, 1000, clk cycles to wait for hopper ack before fault (≥2)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_change_valid  in  1  change request; accepted on a rising edge where i_change_valid && o_ready
- i_change_amt  in  AMT_W  change to return (CNY), sampled on accept
- o_ready  out  1  high only in IDLE
- o_coin_five / o_coin_two / o_coin_one  out  1 each  dispense command, at most one high, held until ack
- i_hopper_ack  in  1  level; hopper has ejected the commanded coin
- i_empty_five / i_empty_two / i_empty_one  in  1 each  hopper tube empty
- o_done  out  1  one-cycle pulse, full change paid
- o_fault  out  1  one-cycle pulse, change cannot be completed (empty tubes or ack timeout)
- o_remaining  out  AMT_W  CNY still owed; holds after done/fault until next accept

## Operation
- States: IDLE, SELECT, DISPENSE, RELEASE, DONE, FAULT.
- IDLE: o_ready=1. On accept, load rem <= i_change_amt, go to SELECT.
- SELECT: exactly one cycle. Choose the denomination from rem and the empty flags, in priority order:
  - rem≥5 && !empty_five → 5
  - else rem≥2 && !empty_two → 2
  - else rem≥1 && !empty_one → 1
  - else rem==0 → DONE
  - else → FAULT
- On a choice of 5, 2 or 1, latch the chosen denomination and go to DISPENSE.
- DISPENSE: assert the latched o_coin_* and run the timeout counter.
  - On i_hopper_ack=1: rem <= rem − denom, drop the command, go to RELEASE.
  - If the counter reaches ACK_TIMEOUT first: go to FAULT with rem unchanged.
  - Empty-flag changes during DISPENSE are ignored; the latched denomination is committed.
- RELEASE: wait for i_hopper_ack=0, then go to SELECT. This state has no timeout.
- DONE: o_done=1 for one cycle, then IDLE.
- FAULT: o_fault=1 for one cycle, then IDLE. o_remaining keeps the unpaid amount.
- Signals ignored by state:
  - i_change_valid outside IDLE.
  - i_hopper_ack in IDLE, SELECT, DONE and FAULT.
  - An ack already high when DISPENSE is entered counts as an ack.
- Greedy selection is not backtracking. Example: rem=3 with one_empty gives a 2, then faults with rem=1. This is the required behaviour.
- Arithmetic: rem is unsigned AMT_W bits. Subtraction never underflows because denom≤rem is guaranteed by SELECT.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, rem=0, timeout counter=0
  - o_ready=1
  - all o_coin_*=0, o_done=0, o_fault=0, o_remaining=0
- Outputs are registered or decoded from the state flop; no combinational path from inputs to outputs.
- Accept at edge N: SELECT during N+1, o_coin_* high from edge N+2.
- Ack seen high at edge M: o_coin_* low and o_remaining updated from M+1; SELECT follows the cycle after ack is seen low.
- Per coin with a 1-cycle ack pulse: 4 cycles (SELECT, DISPENSE ×2, RELEASE).
- Amount 0: o_done pulses in the cycle after SELECT (edge N+2); o_ready returns at N+3.
- Timeout: the counter clears on DISPENSE entry. Fault occurs when the command has been high ACK_TIMEOUT cycles without ack; o_coin_* drops in the same edge that enters FAULT.
- Reset mid-DISPENSE drops o_coin_* asynchronously. After release, the block is in IDLE with o_ready=1.

## Structure
- Shared package vending_pkg holds:
  - denomination constants CNY_ONE=1, CNY_TWO=2, CNY_FIVE=5
  - product price MONEY_PAY=6
  - the dispenser state encoding, as a localparam set
- The coin-accepting FSM and this block both import vending_pkg.
- One natural sub-module: change_denom_select, the purely combinational greedy picker. Inputs: rem and the three empty flags. Outputs: one-hot denomination, is_zero, stuck.
- The FSM, timeout counter and rem register stay in the top module.

## Test plan
- Amount 8, all tubes full, 1-cycle ack 2 cycles after each command → commands five, two, one in that order; o_remaining 8→3→1→0; one o_done pulse; no o_fault.
- Amount 0 → no o_coin_* activity; o_done at accept+2; o_ready back high at accept+3.
- Amount 6, i_empty_five=1 → three two commands; o_done; o_remaining=0.
- Amount 3, i_empty_one=1 → one two command, then o_fault pulse with o_remaining=1; no o_done.
- Amount 5, ack never asserted, ACK_TIMEOUT=16 → o_coin_five high exactly 16 cycles, then o_fault pulse; o_remaining stays 5.
- Amount 7, rst low while o_coin_five high → o_coin_five low immediately (before next clk); after rst release, o_ready=1, o_remaining=0, and a new request is accepted normally.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared vending definitions: coin values, price and
// the change dispenser state encoding.
package vending_pkg;

  localparam int CNY_ONE   = 1;
  localparam int CNY_TWO   = 2;
  localparam int CNY_FIVE  = 5;
  localparam int MONEY_PAY = 6;

  localparam logic [2:0] DS_IDLE     = 3'd0;
  localparam logic [2:0] DS_SELECT   = 3'd1;
  localparam logic [2:0] DS_DISPENSE = 3'd2;
  localparam logic [2:0] DS_RELEASE  = 3'd3;
  localparam logic [2:0] DS_DONE     = 3'd4;
  localparam logic [2:0] DS_FAULT    = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = DS_IDLE,
    SELECT   = DS_SELECT,
    DISPENSE = DS_DISPENSE,
    RELEASE  = DS_RELEASE,
    DONE     = DS_DONE,
    FAULT    = DS_FAULT
  } disp_state_e;

  // one-hot {five, two, one} to coin value
  function automatic logic [2:0] denom_amt(
    input logic [2:0] oh
  );
    logic [2:0] v;
    v = 3'd0;
    unique case (1'b1)
      oh[2]:   v = 3'(CNY_FIVE);
      oh[1]:   v = 3'(CNY_TWO);
      oh[0]:   v = 3'(CNY_ONE);
      default: v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vending_change_if.sv
// Change request and hopper command/ack bundle.
// slave = dispenser side, master = vending FSM + hopper.
interface vending_change_if #(
  parameter int AMT_W = 4
) ();
  logic             i_change_valid;
  logic [AMT_W-1:0] i_change_amt;
  logic             o_ready;
  logic             o_coin_five;
  logic             o_coin_two;
  logic             o_coin_one;
  logic             i_hopper_ack;
  logic             i_empty_five;
  logic             i_empty_two;
  logic             i_empty_one;
  logic             o_done;
  logic             o_fault;
  logic [AMT_W-1:0] o_remaining;

  modport slave (
    input  i_change_valid, i_change_amt,
    input  i_hopper_ack,
    input  i_empty_five, i_empty_two, i_empty_one,
    output o_ready, o_done, o_fault, o_remaining,
    output o_coin_five, o_coin_two, o_coin_one
  );

  modport master (
    output i_change_valid, i_change_amt,
    output i_hopper_ack,
    output i_empty_five, i_empty_two, i_empty_one,
    input  o_ready, o_done, o_fault, o_remaining,
    input  o_coin_five, o_coin_two, o_coin_one
  );
endinterface

// File: rtl/vending_change_dispenser_select.sv
// Greedy coin picker: largest available coin that fits
// the remaining amount; no backtracking.
module change_denom_select
  import vending_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic [AMT_W-1:0] rem,
  input  logic             empty_five,
  input  logic             empty_two,
  input  logic             empty_one,
  output logic [2:0]       denom_oh,
  output logic             is_zero,
  output logic             stuck
);

  always_comb begin
    denom_oh = 3'b000;
    is_zero  = 1'b0;
    stuck    = 1'b0;
    if (rem >= AMT_W'(CNY_FIVE) && !empty_five)
      denom_oh = 3'b100;
    else if (rem >= AMT_W'(CNY_TWO) && !empty_two)
      denom_oh = 3'b010;
    else if (rem >= AMT_W'(CNY_ONE) && !empty_one)
      denom_oh = 3'b001;
    else if (rem == '0)
      is_zero = 1'b1;
    else
      stuck = 1'b1;
  end

endmodule

// File: rtl/vending_change_dispenser.sv
// Change dispenser: pays out rem one coin at a time
// through the hopper command/ack handshake.
module vending_change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int ACK_TIMEOUT = 1000
) (
  input logic            clk,
  input logic            rst,
  vending_change_if.slave bus
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(ACK_TIMEOUT - 1);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       denom_q, denom_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] pick;
  logic       is_zero;
  logic       stuck;

  change_denom_select #(.AMT_W(AMT_W)) u_sel (
    .rem        (rem_q),
    .empty_five (bus.i_empty_five),
    .empty_two  (bus.i_empty_two),
    .empty_one  (bus.i_empty_one),
    .denom_oh   (pick),
    .is_zero    (is_zero),
    .stuck      (stuck)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      denom_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      denom_q <= denom_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    denom_d = denom_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_change_valid) begin
          rem_d   = bus.i_change_amt;
          state_d = SELECT;
        end
      end
      SELECT: begin
        cnt_d   = '0;
        denom_d = pick;
        unique case (1'b1)
          |pick:   state_d = DISPENSE;
          is_zero: state_d = DONE;
          stuck:   state_d = FAULT;
          default: state_d = FAULT;
        endcase
      end
      DISPENSE: begin
        if (bus.i_hopper_ack) begin
          rem_d   = rem_q - AMT_W'(denom_amt(denom_q));
          state_d = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!bus.i_hopper_ack)
          state_d = SELECT;
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // commands decode from state flop, so reset drops them at once
  assign bus.o_coin_five =
    (state_q == DISPENSE) & denom_q[2];
  assign bus.o_coin_two =
    (state_q == DISPENSE) & denom_q[1];
  assign bus.o_coin_one =
    (state_q == DISPENSE) & denom_q[0];

  assign bus.o_ready     = (state_q == IDLE);
  assign bus.o_done      = (state_q == DONE);
  assign bus.o_fault     = (state_q == FAULT);
  assign bus.o_remaining = rem_q;

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Scoreboard bench for vending_change_dispenser with a
// hopper model that acks two cycles after each command.
module tb_vending_change_dispenser;

  localparam int AMT_W = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  vending_change_if #(.AMT_W(AMT_W)) bus ();

  vending_change_dispenser #(
    .AMT_W       (AMT_W),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int sb[$];
  bit ack_en = 1'b1;
  bit no_ack = 1'b0;

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic pop_chk(
    input string tag,
    input int    obs
  );
    if (sb.size() == 0) chk(tag, obs, -1);
    else chk(tag, obs, sb.pop_front());
  endtask

  // events: 1000+coin*100+rem, 2000+rem done, 3000+rem fault
  task automatic model(
    input int amt,
    input bit e5, input bit e2, input bit e1,
    input bit hang
  );
    int r;
    r = amt;
    forever begin
      if (r >= 5 && !e5) begin
        sb.push_back(1500 + r);
        if (hang) begin sb.push_back(3000 + r); break; end
        r -= 5;
      end else if (r >= 2 && !e2) begin
        sb.push_back(1200 + r);
        if (hang) begin sb.push_back(3000 + r); break; end
        r -= 2;
      end else if (r >= 1 && !e1) begin
        sb.push_back(1100 + r);
        if (hang) begin sb.push_back(3000 + r); break; end
        r -= 1;
      end else if (r == 0) begin
        sb.push_back(2000);
        break;
      end else begin
        sb.push_back(3000 + r);
        break;
      end
    end
  endtask

  // hopper model
  initial begin
    int c;
    c = 0;
    bus.i_hopper_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_en && !bus.i_hopper_ack &&
          (bus.o_coin_five | bus.o_coin_two |
           bus.o_coin_one)) begin
        c++;
        if (c == 2) bus.i_hopper_ack = 1'b1;
      end else begin
        bus.i_hopper_ack = 1'b0;
        c = 0;
      end
    end
  end

  // output monitor
  initial begin
    bit any, prev;
    int run, d;
    prev = 1'b0;
    run  = 0;
    forever begin
      @(negedge clk);
      any = bus.o_coin_five | bus.o_coin_two |
            bus.o_coin_one;
      if (any && !prev) begin
        d = bus.o_coin_five ? 5 :
            bus.o_coin_two ? 2 : 1;
        pop_chk("coin",
          1000 + d * 100 + int'(bus.o_remaining));
      end
      if (any) run++;
      if (prev && !any) begin
        if (no_ack) chk("coin_len", run, TMO);
        run = 0;
      end
      if (bus.o_done)
        pop_chk("done", 2000 + int'(bus.o_remaining));
      if (bus.o_fault)
        pop_chk("fault", 3000 + int'(bus.o_remaining));
      prev = any;
    end
  end

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || !bus.o_ready) &&
           k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("drain_timeout", int'(k >= budget), 0);
  endtask

  task automatic run_req(
    input int amt,
    input bit e5, input bit e2, input bit e1,
    input bit hang
  );
    bus.i_empty_five = e5;
    bus.i_empty_two  = e2;
    bus.i_empty_one  = e1;
    ack_en = !hang;
    no_ack = hang;
    model(amt, e5, e2, e1, hang);
    @(posedge clk);
    #1;
    bus.i_change_valid = 1'b1;
    bus.i_change_amt   = AMT_W'(amt);
    @(posedge clk);
    #1;
    bus.i_change_valid = 1'b0;
    drain(300);
    @(posedge clk);
    no_ack = 1'b0;
    ack_en = 1'b1;
  endtask

  initial begin
    int k;
    bus.i_change_valid = 1'b0;
    bus.i_change_amt   = '0;
    bus.i_empty_five   = 1'b0;
    bus.i_empty_two    = 1'b0;
    bus.i_empty_one    = 1'b0;

    #12;
    chk("rst_ready", int'(bus.o_ready), 1);
    chk("rst_rem", int'(bus.o_remaining), 0);
    chk("rst_coin", int'(bus.o_coin_five |
        bus.o_coin_two | bus.o_coin_one), 0);
    chk("rst_done", int'(bus.o_done), 0);
    chk("rst_fault", int'(bus.o_fault), 0);
    @(negedge clk);
    rst = 1'b1;

    run_req(8, 0, 0, 0, 0);

    // amount 0 timing
    model(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    bus.i_change_valid = 1'b1;
    bus.i_change_amt   = '0;
    @(posedge clk);
    #1;
    bus.i_change_valid = 1'b0;
    chk("z_ready_lo", int'(bus.o_ready), 0);
    @(posedge clk);
    #1;
    chk("z_done", int'(bus.o_done), 1);
    chk("z_ready_mid", int'(bus.o_ready), 0);
    @(posedge clk);
    #1;
    chk("z_ready_hi", int'(bus.o_ready), 1);
    chk("z_done_lo", int'(bus.o_done), 0);
    drain(20);

    run_req(6, 1, 0, 0, 0);
    run_req(3, 0, 0, 1, 0);
    run_req(15, 0, 0, 0, 0);
    run_req(5, 0, 0, 0, 1);

    // reset while five is commanded
    bus.i_empty_five = 1'b0;
    bus.i_empty_two  = 1'b0;
    bus.i_empty_one  = 1'b0;
    model(7, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    bus.i_change_valid = 1'b1;
    bus.i_change_amt   = AMT_W'(7);
    @(posedge clk);
    #1;
    bus.i_change_valid = 1'b0;
    k = 0;
    while (!bus.o_coin_five && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst_wait", int'(k >= 20), 0);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_async_five", int'(bus.o_coin_five), 0);
    repeat (2) @(posedge clk);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", int'(bus.o_ready), 1);
    chk("post_rst_rem", int'(bus.o_remaining), 0);
    run_req(7, 0, 0, 0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_chk, n_err);
    $finish;
  end

endmodule
